// File: rtl/issue_queue_ctrl_if.sv
// Handshake bundle between the issue queue controller and its neighbours:
// fetch in, decoder head view, downstream back-pressure and issue results.
interface issue_queue_ctrl_if #(
    parameter int QUEUE_LOG   = 4,
    parameter int STALL_CNT_W = 16
);
    logic                   fetch_valid_in;
    logic [31:0]            fetch_instr_in;
    logic [31:0]            fetch_pc_in;
    logic                   fetch_ready_out;
    logic                   dec_valid_out;
    logic [31:0]            dec_instr_out;
    logic [31:0]            dec_pc_out;
    logic                   dec_is_mem_in;
    logic                   rob_full_in;
    logic                   rs_full_in;
    logic                   lsb_full_in;
    logic                   issue_out;
    logic                   issue_rs_out;
    logic                   issue_lsb_out;
    logic [31:0]            issue_instr_out;
    logic [31:0]            issue_pc_out;
    logic [QUEUE_LOG:0]     count_out;
    logic [STALL_CNT_W-1:0] stall_cnt_out;

    // Queue controller side
    modport slave (
        input  fetch_valid_in, fetch_instr_in, fetch_pc_in,
        input  dec_is_mem_in, rob_full_in, rs_full_in, lsb_full_in,
        output fetch_ready_out, dec_valid_out, dec_instr_out, dec_pc_out,
        output issue_out, issue_rs_out, issue_lsb_out,
        output issue_instr_out, issue_pc_out, count_out, stall_cnt_out
    );

    // Surrounding pipeline side (fetch, decoder, ROB/RS/LSB)
    modport master (
        output fetch_valid_in, fetch_instr_in, fetch_pc_in,
        output dec_is_mem_in, rob_full_in, rs_full_in, lsb_full_in,
        input  fetch_ready_out, dec_valid_out, dec_instr_out, dec_pc_out,
        input  issue_out, issue_rs_out, issue_lsb_out,
        input  issue_instr_out, issue_pc_out, count_out, stall_cnt_out
    );
endinterface

// File: rtl/issue_queue_ctrl.sv
// Instruction queue between fetch and decode. A circular FIFO holds fetched
// instructions, the head is shown to the decoder, and the decoder's mem/non-mem
// verdict routes the head to the RS or the LSB subject to back-pressure.
module issue_queue_ctrl #(
    parameter int QUEUE_LOG   = 4,
    parameter int STALL_CNT_W = 16
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic               clr_in,
    issue_queue_ctrl_if.slave  bus
);
    localparam int DEPTH = 1 << QUEUE_LOG;
    localparam logic [QUEUE_LOG:0] DEPTH_CNT = (QUEUE_LOG+1)'(DEPTH);

    logic [31:0]            instrMem_q [DEPTH];
    logic [31:0]            pcMem_q    [DEPTH];

    logic [QUEUE_LOG-1:0]   head_q, head_d;
    logic [QUEUE_LOG-1:0]   tail_q, tail_d;
    logic [QUEUE_LOG:0]     count_q, count_d;
    logic                   issue_q, issue_d;
    logic                   issueRs_q, issueRs_d;
    logic                   issueLsb_q, issueLsb_d;
    logic [31:0]            issueInstr_q, issueInstr_d;
    logic [31:0]            issuePc_q, issuePc_d;
    logic [STALL_CNT_W-1:0] stallCnt_q, stallCnt_d;

    logic fetchReady;
    logic decValid;
    logic push;
    logic go;

    // Full queue refuses fetch outright, so a same-cycle pop never lets a push through
    assign fetchReady = (count_q < DEPTH_CNT);
    assign decValid   = (count_q != '0);
    assign push = bus.fetch_valid_in && fetchReady && !clr_in;
    assign go   = decValid && !bus.rob_full_in
                  && (bus.dec_is_mem_in ? !bus.lsb_full_in : !bus.rs_full_in)
                  && !clr_in;

    // Next-state for pointers, occupancy, issue register and stall counter
    always_comb begin
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        issue_d      = 1'b0;
        issueRs_d    = 1'b0;
        issueLsb_d   = 1'b0;
        issueInstr_d = issueInstr_q;
        issuePc_d    = issuePc_q;
        stallCnt_d   = stallCnt_q;

        if (clr_in) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                tail_d = tail_q + QUEUE_LOG'(1);
            end
            if (go) begin
                head_d = head_q + QUEUE_LOG'(1);
            end
            if (push && !go) begin
                count_d = count_q + (QUEUE_LOG+1)'(1);
            end else if (!push && go) begin
                count_d = count_q - (QUEUE_LOG+1)'(1);
            end
        end

        if (go) begin
            issue_d      = 1'b1;
            issueRs_d    = !bus.dec_is_mem_in;
            issueLsb_d   = bus.dec_is_mem_in;
            issueInstr_d = instrMem_q[head_q];
            issuePc_d    = pcMem_q[head_q];
        end

        if (decValid && !go && !clr_in && (stallCnt_q != '1)) begin
            stallCnt_d = stallCnt_q + STALL_CNT_W'(1);
        end
    end

    // Entry storage needs no reset: count_q decides which slots are meaningful
    always_ff @(posedge clk_in) begin
        if (!rst_in && rdy_in && push) begin
            instrMem_q[tail_q] <= bus.fetch_instr_in;
            pcMem_q[tail_q]    <= bus.fetch_pc_in;
        end
    end

    // Control state register; reset wins over the rdy freeze
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            issue_q      <= 1'b0;
            issueRs_q    <= 1'b0;
            issueLsb_q   <= 1'b0;
            issueInstr_q <= '0;
            issuePc_q    <= '0;
            stallCnt_q   <= '0;
        end else if (rdy_in) begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            issue_q      <= issue_d;
            issueRs_q    <= issueRs_d;
            issueLsb_q   <= issueLsb_d;
            issueInstr_q <= issueInstr_d;
            issuePc_q    <= issuePc_d;
            stallCnt_q   <= stallCnt_d;
        end
    end

    assign bus.fetch_ready_out = fetchReady;
    assign bus.dec_valid_out   = decValid;
    assign bus.dec_instr_out   = instrMem_q[head_q];
    assign bus.dec_pc_out      = pcMem_q[head_q];
    assign bus.issue_out       = issue_q;
    assign bus.issue_rs_out    = issueRs_q;
    assign bus.issue_lsb_out   = issueLsb_q;
    assign bus.issue_instr_out = issueInstr_q;
    assign bus.issue_pc_out    = issuePc_q;
    assign bus.count_out       = count_q;
    assign bus.stall_cnt_out   = stallCnt_q;
endmodule

// File: doc/issue_queue_ctrl.md
Name: issue_queue_ctrl

Overview:
- Instruction queue and dispatch controller sitting between the fetch unit and the decoder.
- Buffers fetched instructions in a circular FIFO and presents the head entry to the decoder combinationally.
- Uses the decoder's memory/non-memory classification of the head to issue it to the reservation station (RS) or load/store buffer (LSB), gated by ROB/RS/LSB back-pressure.
- Supports pipeline flush on misprediction and global pause via rdy_in.

Parameters:
- QUEUE_LOG, 4, log2 of queue depth; depth = 2^QUEUE_LOG = 16 entries.
- STALL_CNT_W, 16, width of the saturating stall counter.

Ports:
- clk_in  input  1  clock; all state updates on rising edge.
- rst_in  input  1  synchronous reset, active-high.
- rdy_in  input  1  global enable; low freezes all state.
- clr_in  input  1  flush (branch mispredict); empties queue.
- fetch_valid_in  input  1  fetch offers an instruction.
- fetch_instr_in  input  32  instruction word.
- fetch_pc_in  input  32  instruction address.
- fetch_ready_out  output  1  queue can accept; = (count < 2^QUEUE_LOG).
- dec_valid_out  output  1  head entry present; = (count != 0).
- dec_instr_out  output  32  head instruction, to decoder instr_in.
- dec_pc_out  output  32  head pc, to decoder pc_in.
- dec_is_mem_in  input  1  decoder classifies head as load/store.
- rob_full_in  input  1  ROB cannot accept.
- rs_full_in  input  1  RS cannot accept.
- lsb_full_in  input  1  LSB cannot accept.
- issue_out  output  1  one-cycle pulse: instruction issued.
- issue_rs_out  output  1  issued instruction targets RS.
- issue_lsb_out  output  1  issued instruction targets LSB.
- issue_instr_out  output  32  issued instruction word (registered).
- issue_pc_out  output  32  issued pc (registered).
- count_out  output  QUEUE_LOG+1  current occupancy.
- stall_cnt_out  output  STALL_CNT_W  cycles head was valid but blocked (saturating).

Behaviour:
- Reset (rst_in=1, checked before rdy_in): head=tail=count=0; issue_out, issue_rs_out, issue_lsb_out=0; issue_instr_out=issue_pc_out=0; stall_cnt_out=0.
- rdy_in=0 (no reset): every register holds, including issue_* outputs. Downstream units are gated by the same rdy_in.
- Push condition: push = fetch_valid_in & fetch_ready_out & !clr_in. Writes entry[tail] and increments tail modulo depth.
- Issue condition: go = dec_valid_out & !rob_full_in & (dec_is_mem_in ? !lsb_full_in : !rs_full_in) & !clr_in.
- On go: pop head; next cycle issue_out=1, issue_lsb_out=dec_is_mem_in, issue_rs_out=!dec_is_mem_in, and issue_instr_out/issue_pc_out take the head values. Latency is 1 cycle.
- When go is not taken: issue_out, issue_rs_out and issue_lsb_out are 0 next cycle. issue_instr_out and issue_pc_out hold their values.
- Throughput: at most one issue per cycle.
- Push and pop in the same cycle: both take effect and count is unchanged.
- Full queue: fetch_ready_out=0, so a push is never accepted, even if a pop happens that cycle (no pass-through).
- Empty queue: a pushed entry is not issued in the same cycle (no bypass). The earliest issue is the following cycle.
- Pointers wrap modulo 2^QUEUE_LOG. count distinguishes full from empty.
- clr_in=1 (with rdy_in=1): head=tail=count=0 next cycle; issue_out, issue_rs_out and issue_lsb_out=0 next cycle; the same-cycle push is dropped; stall_cnt_out is unaffected.
- stall_cnt_out increments when dec_valid_out & !go & !clr_in, and saturates at all-ones.
- Blocking is per-target: a blocked non-mem head with rs_full_in=1 stalls even when lsb_full_in=0. Dispatch is strictly in order.

Test Plan:
- Reset, then push 3 instructions (pc 0x0,0x4,0x8) with all fulls low → issue_out pulses on 3 consecutive cycles starting 2 cycles after the first push; issue_pc_out = 0x0,0x4,0x8; count_out returns to 0.
- Fill 16 entries with rob_full_in=1 → fetch_ready_out=0 and count_out=16. Assert a push and release rob_full_in in the same cycle → push is rejected; count_out=15 next cycle.
- Head is a load (dec_is_mem_in=1) with lsb_full_in=1 and rs_full_in=0 for 5 cycles → no issue and stall_cnt_out=5. Release lsb_full_in → issue_lsb_out=1, issue_rs_out=0.
- Queue holds 6 entries; assert clr_in together with fetch_valid_in → next cycle count_out=0, issue_out=0, and the pushed entry is absent.
- Mid-stream rdy_in=0 for 4 cycles → count_out, issue_* and pointers are unchanged. Issue resumes in order after rdy_in=1.
- Push 20 entries with continuous draining → pointer wrap is correct: issue_pc_out sequence 0x0..0x4C with no loss or duplication.
